// File: rtl/screen_framebuffer.sv
// Banked pixel framebuffer between the drawing logic (write port) and the
// SPI screen controller (read port). One write and one read per cycle, a
// 1-cycle read pipeline, and a fill engine that paints the whole buffer
// one pixel per cycle while busy is high.
module screen_framebuffer #(
   parameter int WIDTH          = 128,
   parameter int HEIGHT         = 128,
   parameter int PIX_W          = 16,
   parameter int BANK_ROWS      = 64,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [XW-1:0]    rd_addr_x,
   input  logic [YW-1:0]    rd_addr_y,
   output logic [PIX_W-1:0] data_out,
   output logic             valid_out,
   input  logic             wr_en,
   input  logic [XW-1:0]    wr_addr_x,
   input  logic [YW-1:0]    wr_addr_y,
   input  logic [PIX_W-1:0] data_in,
   input  logic             fill_start,
   input  logic [PIX_W-1:0] fill_color,
   output logic             busy
);

   localparam int NB         = (HEIGHT + BANK_ROWS - 1) / BANK_ROWS;
   localparam int BANK_DEPTH = BANK_ROWS * WIDTH;
   localparam int LW         = $clog2(BANK_DEPTH);
   localparam int BW         = (NB > 1) ? $clog2(NB) : 1;
   localparam int NPIX       = WIDTH * HEIGHT;
   localparam int CW         = $clog2(NPIX);

   localparam logic [CW-1:0] FILL_LAST = CW'(NPIX - 1);
   localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_FILL
   } state_t;

   // Address mapping: rows are split into banks of BANK_ROWS rows; inside a
   // bank pixels are stored row-major.
   function automatic logic f_in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
   endfunction

   function automatic logic [BW-1:0] f_bank(input logic [YW-1:0] y);
      return BW'(int'(y) / BANK_ROWS);
   endfunction

   function automatic logic [LW-1:0] f_local(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return LW'((int'(y) % BANK_ROWS) * WIDTH + int'(x));
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_fill_go;
   logic             w_fill_last;
   logic             w_busy;

   logic [CW-1:0]    r_fill_cnt;
   logic [XW-1:0]    r_fill_x;
   logic [YW-1:0]    r_fill_y;
   logic [PIX_W-1:0] r_fill_color;
   logic             r_clear_pend;

   logic             w_we;
   logic [XW-1:0]    w_wx;
   logic [YW-1:0]    w_wy;
   logic [PIX_W-1:0] w_wdata;
   logic [BW-1:0]    w_wbank;
   logic [LW-1:0]    w_waddr;

   logic             w_rd_acc;
   logic             w_rd_oob;
   logic             w_re;
   logic [BW-1:0]    w_rbank;
   logic [LW-1:0]    w_raddr;

   logic             r_valid;
   logic             r_rd_oob;
   logic [BW-1:0]    r_rd_bank;
   logic [PIX_W-1:0] w_bank_q [NB];

   assign w_busy = (r_state == S_FILL);
   assign busy   = w_busy;

   // State register for the IDLE/FILL controller.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic: a pending post-reset clear or a fill_start launches a fill.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_fill_go   = 1'b0;
      w_fill_last = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_clear_pend || fill_start) begin
               w_state_nxt = S_FILL;
               w_fill_go   = 1'b1;
            end
         end
         S_FILL: begin
            w_fill_last = (r_fill_cnt == FILL_LAST);
            if (w_fill_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Fill engine: linear pixel counter plus x/y walk, x fastest; holds at the last pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_cnt   <= '0;
         r_fill_x     <= '0;
         r_fill_y     <= '0;
         r_fill_color <= '0;
         r_clear_pend <= CLEAR_ON_RESET;
      end else if (w_fill_go) begin
         r_fill_cnt   <= '0;
         r_fill_x     <= '0;
         r_fill_y     <= '0;
         r_fill_color <= r_clear_pend ? '0 : fill_color;
         r_clear_pend <= 1'b0;
      end else if (w_busy && !w_fill_last) begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
         if (r_fill_x == X_LAST) begin
            r_fill_x <= '0;
            r_fill_y <= r_fill_y + 1'b1;
         end else begin
            r_fill_x <= r_fill_x + 1'b1;
         end
      end
   end

   // Write port: the fill engine owns the port while busy; out-of-range external writes are dropped.
   always_comb begin
      w_wx    = w_busy ? r_fill_x     : wr_addr_x;
      w_wy    = w_busy ? r_fill_y     : wr_addr_y;
      w_wdata = w_busy ? r_fill_color : data_in;
      w_we    = !rst && (w_busy || (wr_en && f_in_range(wr_addr_x, wr_addr_y)));
      w_wbank = f_bank(w_wy);
      w_waddr = f_local(w_wx, w_wy);
   end

   // Read port: accepted only when idle; out-of-range reads skip the memories and return 0.
   always_comb begin
      w_rd_acc = rd_en && !w_busy && !rst;
      w_rd_oob = !f_in_range(rd_addr_x, rd_addr_y);
      w_re     = w_rd_acc && !w_rd_oob;
      w_rbank  = f_bank(rd_addr_y);
      w_raddr  = f_local(rd_addr_x, rd_addr_y);
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      logic [PIX_W-1:0] r_mem [BANK_DEPTH];
      logic [PIX_W-1:0] r_q;

      // Single-port-style bank: write and registered read; a same-address read sees the old word.
      always_ff @(posedge clk) begin
         // NOTE: storage and its read register have no reset; reset leaves memory contents alone.
         if (w_we && (w_wbank == BW'(b))) r_mem[w_waddr] <= w_wdata;
         if (w_re && (w_rbank == BW'(b))) r_q <= r_mem[w_raddr];
      end

      assign w_bank_q[b] = r_q;
   end

   // Read pipeline side-band: valid, out-of-range flag and bank select travel with the read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_rd_oob  <= 1'b1;
         r_rd_bank <= '0;
      end else begin
         r_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_oob  <= w_rd_oob;
            r_rd_bank <= w_rbank;
         end
      end
   end

   assign valid_out = r_valid;

   // Output mux; every input to it only changes on an accepted read, so data_out holds between reads.
   always_comb begin
      data_out = '0;
      for (int b = 0; b < NB; b++) begin
         if (!r_rd_oob && (r_rd_bank == BW'(b))) data_out = w_bank_q[b];
      end
   end

endmodule

// File: tb/tb_screen_framebuffer.sv
// Self-checking bench for screen_framebuffer. Instance A uses the default
// 128x128 geometry without clear-on-reset; instance B uses 160x80 with
// 32-row banks and clear-on-reset. A pixel-array reference model predicts
// every output cycle by cycle.
module tb_screen_framebuffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A signals (128x128, 64-row banks, no clear on reset)
   logic        a_rst = 1'b1, a_rd_en = 1'b0, a_wr_en = 1'b0, a_fill_start = 1'b0;
   logic [6:0]  a_rx = '0, a_ry = '0, a_wx = '0, a_wy = '0;
   logic [15:0] a_din = '0, a_fc = '0;
   logic [15:0] a_dout;
   logic        a_valid, a_busy;

   // Instance B signals (160x80, 32-row banks, clear on reset)
   logic        b_rst = 1'b1, b_rd_en = 1'b0, b_wr_en = 1'b0, b_fill_start = 1'b0;
   logic [7:0]  b_rx = '0, b_wx = '0;
   logic [6:0]  b_ry = '0, b_wy = '0;
   logic [15:0] b_din = '0, b_fc = '0;
   logic [15:0] b_dout;
   logic        b_valid, b_busy;

   screen_framebuffer #(
      .WIDTH(128), .HEIGHT(128), .PIX_W(16), .BANK_ROWS(64), .CLEAR_ON_RESET(1'b0)
   ) u_dut_a (
      .clk(clk), .rst(a_rst),
      .rd_en(a_rd_en), .rd_addr_x(a_rx), .rd_addr_y(a_ry),
      .data_out(a_dout), .valid_out(a_valid),
      .wr_en(a_wr_en), .wr_addr_x(a_wx), .wr_addr_y(a_wy), .data_in(a_din),
      .fill_start(a_fill_start), .fill_color(a_fc), .busy(a_busy)
   );

   screen_framebuffer #(
      .WIDTH(160), .HEIGHT(80), .PIX_W(16), .BANK_ROWS(32), .CLEAR_ON_RESET(1'b1)
   ) u_dut_b (
      .clk(clk), .rst(b_rst),
      .rd_en(b_rd_en), .rd_addr_x(b_rx), .rd_addr_y(b_ry),
      .data_out(b_dout), .valid_out(b_valid),
      .wr_en(b_wr_en), .wr_addr_x(b_wx), .wr_addr_y(b_wy), .data_in(b_din),
      .fill_start(b_fill_start), .fill_color(b_fc), .busy(b_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: flat pixel array indexed y*W+x, plus fill bookkeeping
   logic [15:0] mdl       [20480];
   bit          mdl_known [20480];
   int          sel = 0;
   int          m_w = 128, m_h = 128;
   bit          m_clr_param = 1'b0, m_clear_pend = 1'b0;
   int          m_rem = 0, m_fidx = 0;
   logic [15:0] m_fcol = '0;
   logic        exp_valid = 1'b0, exp_busy = 1'b0;
   logic [15:0] exp_data = '0;
   bit          exp_known = 1'b1;

   logic        obs_valid, obs_busy;
   logic [15:0] obs_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_start_fill(input logic [15:0] c);
      m_rem  = m_w * m_h;
      m_fidx = 0;
      m_fcol = c;
   endtask

   // One clock cycle: drive inputs, advance the model, then compare outputs after the edge.
   task automatic step(input bit r, input bit rd, input int rx, input int ry,
                       input bit wr, input int wx, input int wy, input logic [15:0] wd,
                       input bit fs, input logic [15:0] fc);
      if (sel == 0) begin
         a_rst = r; a_rd_en = rd; a_rx = 7'(rx); a_ry = 7'(ry);
         a_wr_en = wr; a_wx = 7'(wx); a_wy = 7'(wy); a_din = wd;
         a_fill_start = fs; a_fc = fc;
      end else begin
         b_rst = r; b_rd_en = rd; b_rx = 8'(rx); b_ry = 7'(ry);
         b_wr_en = wr; b_wx = 8'(wx); b_wy = 7'(wy); b_din = wd;
         b_fill_start = fs; b_fc = fc;
      end

      if (r) begin
         m_rem        = 0;
         exp_valid    = 1'b0;
         exp_data     = '0;
         exp_known    = 1'b1;
         m_clear_pend = m_clr_param;
      end else if (m_rem > 0) begin
         mdl[m_fidx]       = m_fcol;
         mdl_known[m_fidx] = 1'b1;
         m_fidx++;
         m_rem--;
         exp_valid = 1'b0;
      end else begin
         if (rd) begin
            exp_valid = 1'b1;
            if (rx < m_w && ry < m_h) begin
               exp_data  = mdl[ry * m_w + rx];
               exp_known = mdl_known[ry * m_w + rx];
            end else begin
               exp_data  = '0;
               exp_known = 1'b1;
            end
         end else begin
            exp_valid = 1'b0;
         end
         if (wr && wx < m_w && wy < m_h) begin
            mdl[wy * m_w + wx]       = wd;
            mdl_known[wy * m_w + wx] = 1'b1;
         end
         if (m_clear_pend) begin
            model_start_fill(16'h0000);
            m_clear_pend = 1'b0;
         end else if (fs) begin
            model_start_fill(fc);
         end
      end
      exp_busy = (m_rem > 0);

      @(posedge clk);
      #1;
      obs_valid = (sel == 0) ? a_valid : b_valid;
      obs_busy  = (sel == 0) ? a_busy  : b_busy;
      obs_data  = (sel == 0) ? a_dout  : b_dout;
      check("busy", obs_busy, exp_busy);
      check("valid_out", obs_valid, exp_valid);
      if (exp_known) check("data_out", obs_data, exp_data);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic rd(input int x, input int y);
      step(1'b0, 1'b1, x, y, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic wr(input int x, input int y, input logic [15:0] d);
      step(1'b0, 1'b0, 0, 0, 1'b1, x, y, d, 1'b0, 16'h0);
   endtask

   // Random read/write; instance B also draws out-of-range coordinates
   task automatic rand_op(input bit with_fs);
      int xr, yr;
      xr = m_w - 1 + ((sel == 1) ? 16 : 0);
      yr = m_h - 1 + ((sel == 1) ? 16 : 0);
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, xr)), int'($urandom_range(0, yr)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, xr)), int'($urandom_range(0, yr)),
           16'($urandom), with_fs && ($urandom_range(0, 63) == 0), 16'($urandom));
   endtask

   // Run a fill to completion with random traffic, counting observed busy cycles
   task automatic run_fill(input string tag, input bit start, input logic [15:0] col);
      int busy_cycles = 0;
      if (start) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b1, col);
      else       rand_op(1'b0);
      if (obs_busy) busy_cycles++;
      for (int i = 0; i < m_w * m_h + 16 && m_rem > 0; i++) begin
         rand_op(1'b1);
         if (obs_busy) busy_cycles++;
      end
      check(tag, busy_cycles, m_w * m_h);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);

      // ---------------- Instance A ----------------
      sel = 0; m_w = 128; m_h = 128; m_clr_param = 1'b0;
      for (int i = 0; i < 20480; i++) mdl_known[i] = 1'b0;

      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
      check("rst_valid", obs_valid, 1'b0);
      check("rst_data", obs_data, 16'h0000);
      check("rst_busy", obs_busy, 1'b0);
      idle();
      check("idle_busy", obs_busy, 1'b0);

      // Bank boundary at y=64
      wr(5, 3, 16'hF800);
      wr(5, 70, 16'h07E0);
      rd(5, 3);
      check("rd_b0_valid", obs_valid, 1'b1);
      check("rd_b0_data", obs_data, 16'hF800);
      rd(5, 70);
      check("rd_b1_valid", obs_valid, 1'b1);
      check("rd_b1_data", obs_data, 16'h07E0);
      idle();
      check("hold_valid", obs_valid, 1'b0);
      check("hold_data", obs_data, 16'h07E0);

      // Same-address collision: old data first, new data next
      wr(10, 10, 16'h1234);
      step(1'b0, 1'b1, 10, 10, 1'b1, 10, 10, 16'hABCD, 1'b0, 16'h0);
      check("collide_old", obs_data, 16'h1234);
      rd(10, 10);
      check("collide_new", obs_data, 16'hABCD);

      // Read and write to different addresses in one cycle
      step(1'b0, 1'b1, 5, 3, 1'b1, 20, 100, 16'h5A5A, 1'b0, 16'h0);
      check("dual_rd", obs_data, 16'hF800);
      rd(20, 100);
      check("dual_wr", obs_data, 16'h5A5A);

      for (int i = 0; i < 200; i++) rand_op(1'b0);

      // Full fill with ignored traffic
      run_fill("fill_cycles_a", 1'b1, 16'h001F);
      rd(0, 0);
      check("fill_00", obs_data, 16'h001F);
      rd(127, 127);
      check("fill_last", obs_data, 16'h001F);
      rd(64, 63);
      check("fill_mid", obs_data, 16'h001F);

      for (int i = 0; i < 200; i++) rand_op(1'b0);

      // Write and fill in the same idle cycle: the fill wins
      step(1'b0, 1'b0, 0, 0, 1'b1, 3, 0, 16'hBEEF, 1'b1, 16'h0F0F);
      for (int i = 0; i < m_w * m_h + 16 && m_rem > 0; i++) idle();
      rd(3, 0);
      check("wr_then_fill", obs_data, 16'h0F0F);

      // Reset mid-fill: pixel 199 is (71,1), pixel 300 is (44,2)
      wr(71, 1, 16'h5555);
      wr(44, 2, 16'h5555);
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b1, 16'h7C00);
      for (int i = 0; i < 200; i++) idle();
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
      check("abort_busy", obs_busy, 1'b0);
      idle();
      check("abort_idle", obs_busy, 1'b0);
      rd(71, 1);
      check("abort_px199", obs_data, 16'h7C00);
      rd(44, 2);
      check("abort_px300", obs_data, 16'h5555);
      for (int i = 0; i < 100; i++) rand_op(1'b0);

      // ---------------- Instance B ----------------
      a_rst = 1'b1;
      sel = 1; m_w = 160; m_h = 80; m_clr_param = 1'b1;
      m_rem = 0; exp_valid = 1'b0; exp_data = '0; exp_known = 1'b1;
      for (int i = 0; i < 20480; i++) mdl_known[i] = 1'b0;

      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 16'h0, 1'b0, 16'h0);
      check("b_rst_busy", obs_busy, 1'b0);
      run_fill("clear_cycles_b", 1'b0, 16'h0000);
      rd(100, 50);
      check("b_cleared", obs_data, 16'h0000);

      wr(0, 0, 16'h1111);
      wr(159, 0, 16'h2222);
      wr(0, 79, 16'h3333);
      wr(159, 79, 16'h4444);
      wr(0, 32, 16'h5555);
      wr(159, 64, 16'h6666);
      wr(170, 5, 16'h7777);
      rd(0, 0);     check("b_c00", obs_data, 16'h1111);
      rd(159, 0);   check("b_c10", obs_data, 16'h2222);
      rd(0, 79);    check("b_c01", obs_data, 16'h3333);
      rd(159, 79);  check("b_c11", obs_data, 16'h4444);
      rd(0, 32);    check("b_bank1", obs_data, 16'h5555);
      rd(159, 64);  check("b_bank2", obs_data, 16'h6666);
      rd(10, 90);
      check("b_oob_valid", obs_valid, 1'b1);
      check("b_oob_data", obs_data, 16'h0000);
      rd(170, 5);
      check("b_oobx_data", obs_data, 16'h0000);
      rd(10, 5);
      check("b_oob_wr_dropped", obs_data, 16'h0000);

      for (int i = 0; i < 300; i++) rand_op(1'b0);

      run_fill("fill_cycles_b", 1'b1, 16'hC3A5);
      rd(159, 79);
      check("b_fill_last", obs_data, 16'hC3A5);
      for (int i = 0; i < 200; i++) rand_op(1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/screen_framebuffer.md
Name: screen_framebuffer

Overview:
- Parametrised, banked pixel framebuffer for the ST7735 display path. Sits between the drawing logic (write port) and the SPI screen controller (read port).
- Generalises the fixed 128x128x16 two-bank buffer to any geometry, with true storage and a 1-cycle read pipeline.
- Adds a hardware fill/clear engine and a busy handshake.

Parameters:
- WIDTH, 128, pixels per row.
- HEIGHT, 128, rows.
- PIX_W, 16, bits per pixel (RGB565 by default).
- BANK_ROWS, 64, rows per memory bank. Bank count NB = ceil(HEIGHT/BANK_ROWS). Each bank holds BANK_ROWS*WIDTH words, which maps to one SB_SPRAM256KA at the defaults.
- CLEAR_ON_RESET, 1. When 1, the block runs a fill with colour 0 after reset.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request
- rd_addr_x  in  XW=$clog2(WIDTH)  read column
- rd_addr_y  in  YW=$clog2(HEIGHT)  read row
- data_out  out  PIX_W  read data
- valid_out  out  1  data_out valid, 1 cycle after an accepted rd_en
- wr_en  in  1  write request
- wr_addr_x  in  XW  write column
- wr_addr_y  in  YW  write row
- data_in  in  PIX_W  write pixel
- fill_start  in  1  single-cycle pulse; start a fill of the whole buffer
- fill_color  in  PIX_W  fill colour, sampled on the cycle fill_start is accepted
- busy  out  1  fill in progress; external reads and writes are ignored

Behaviour:
- Address mapping:
  - bank = y / BANK_ROWS
  - local address = (y mod BANK_ROWS)*WIDTH + x
  - With power-of-two geometry this is pure bit slicing: {y[low bits], x}.
- Only the selected bank is write-enabled; the others see WREN=0 and MASKWREN=0.
- Out-of-range address (x>=WIDTH or y>=HEIGHT):
  - write is dropped;
  - read is accepted and returns 0 with valid_out=1.
- Read pipeline, 1-cycle latency:
  - rd_en accepted at cycle N (busy=0) gives valid_out=1 and data_out=mem[addr] at cycle N+1.
  - Back-to-back reads sustain one read per cycle.
  - valid_out=0 when no read was accepted at N.
  - data_out holds its last value when valid_out=0.
  - Bank select for the output mux is registered alongside the read.
- Simultaneous rd_en and wr_en, idle, same address: read returns the old data (read-before-write). The new data is visible from the next read.
- Simultaneous rd_en and wr_en, different addresses: both complete in the same cycle.
- State machine: IDLE, FILL.
  - IDLE: fill_start=1 moves to FILL next cycle and latches fill_color. busy=1 from the following cycle.
  - FILL:
    - Writes the latched colour to one pixel per cycle, in linear order from (0,0), x fastest.
    - A counter of width $clog2(WIDTH*HEIGHT) drives the addresses.
    - Returns to IDLE after the write to (WIDTH-1, HEIGHT-1).
    - Duration is exactly WIDTH*HEIGHT cycles; busy falls on the cycle after the last write.
  - While busy=1:
    - rd_en, wr_en and fill_start are ignored (no re-trigger);
    - valid_out stays 0.
  - fill_start and wr_en in the same IDLE cycle: the write completes, then the fill starts and overwrites it.
- Reset (rst=1 at posedge):
  - state=IDLE, fill counter=0, valid_out=0, data_out=0, busy=0.
  - Memory contents are not otherwise altered.
  - Reset during FILL aborts the fill immediately. Pixels already written keep fill_color; the rest keep old data.
  - If CLEAR_ON_RESET=1: the first cycle after rst deasserts enters FILL with colour 0, and busy=1 for WIDTH*HEIGHT cycles.
- The fill counter does not wrap: it saturates at the terminal count and the state exits.
- Widths are computed from parameters. No truncation is allowed when HEIGHT is not a multiple of BANK_ROWS; the last bank is partly used.

Test Plan:
- Reset: CLEAR_ON_RESET=0, rst held 2 cycles -> valid_out=0, data_out=0, busy=0.
- Write/read: write 16'hF800 at (5,3) and 16'h07E0 at (5,70), then read both back-to-back -> valid_out=1 on consecutive cycles with F800 then 07E0. Confirms the bank boundary at y=64.
- Same-address collision: (10,10) holds 16'h1234. Read and write 16'hABCD to it in the same cycle -> data_out=1234; next read gives ABCD.
- Fill: pulse fill_start with fill_color=16'h001F -> busy=1 for exactly 16384 cycles. Reads and writes issued during busy are ignored and valid_out stays 0. Afterwards reads of (0,0), (127,127) and (64,63) all return 001F.
- Reset mid-fill: assert rst at fill cycle 200 -> busy=0 next cycle. Pixel index 199 reads the fill colour; pixel index 300 keeps its pre-fill value.
- Parameter sweep: WIDTH=160, HEIGHT=80, BANK_ROWS=32 (3 banks, last partly used) -> write and read corner pixels; out-of-range read at y=90 returns 0 with valid_out=1; fill takes exactly 12800 cycles.
